// File: rtl/rv64if_mem_subsystem_if.sv
// Bus bundle between the RV64IF core/boot host and the memory responder.
// The master side drives requests and the boot stream; the slave side answers them.
interface rv64if_mem_subsystem_if;
  logic [7:0]  in_load_byte;
  logic        in_load_valid;
  logic        in_load_last;
  logic        out_load_ready;
  logic [63:0] in_inst_addr;
  logic [31:0] out_inst;
  logic [63:0] in_addr;
  logic [63:0] in_wr_data;
  logic        in_DM_wr_en;
  logic [63:0] out_DM_data;
  logic        out_core_Rst_N;
  logic        out_load_done;
  logic        out_err;

  modport master (
    output in_load_byte, in_load_valid, in_load_last,
    output in_inst_addr, in_addr, in_wr_data, in_DM_wr_en,
    input  out_load_ready, out_inst, out_DM_data,
    input  out_core_Rst_N, out_load_done, out_err
  );

  modport slave (
    input  in_load_byte, in_load_valid, in_load_last,
    input  in_inst_addr, in_addr, in_wr_data, in_DM_wr_en,
    output out_load_ready, out_inst, out_DM_data,
    output out_core_Rst_N, out_load_done, out_err
  );
endinterface

// File: rtl/rv64if_mem_subsystem.sv
// Instruction ROM + data RAM behind the RV64IF core, with a boot loader that
// fills the ROM from a byte stream and holds the core in reset until it is done.
module rv64if_mem_subsystem #(
  parameter int IMEM_WORDS  = 1024,
  parameter int DMEM_DWORDS = 512
) (
  input logic                  in_Clk,
  input logic                  in_Rst,
  rv64if_mem_subsystem_if.slave bus
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_DWORDS);
  localparam logic [63:0] IMEM_BYTES = 64'(IMEM_WORDS) << 2;
  localparam logic [63:0] DMEM_BYTES = 64'(DMEM_DWORDS) << 3;
  localparam logic [IW:0] WCNT_FULL  = (IW+1)'(IMEM_WORDS);
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [IW:0] wcnt_q, wcnt_d;
  logic [31:0] asm_q, asm_d;
  logic        err_q, err_d;
  logic        core_rst_n_q, core_rst_n_d;
  logic        done_q, done_d;

  logic          imem_we;
  logic [IW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          dmem_we;

  logic [31:0] imem [IMEM_WORDS];
  logic [63:0] dmem [DMEM_DWORDS];

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    wcnt_d       = wcnt_q;
    asm_d        = asm_q;
    err_d        = err_q;
    core_rst_n_d = core_rst_n_q;
    done_d       = done_q;
    imem_we      = 1'b0;
    imem_waddr   = wcnt_q[IW-1:0];
    // Upper lanes of asm_q are still zero, which gives the padding on a short last word.
    imem_wdata   = asm_q | ({24'b0, bus.in_load_byte} << {lane_q, 3'b000});
    case (state_q)
      S_LOAD: begin
        if (bus.in_load_valid) begin
          if (wcnt_q == WCNT_FULL) begin
            err_d = 1'b1;
          end else if (lane_q == 2'd3 || bus.in_load_last) begin
            imem_we = 1'b1;
            wcnt_d  = wcnt_q + (IW+1)'(1);
            lane_d  = 2'd0;
            asm_d   = 32'b0;
          end else begin
            lane_d = lane_q + 2'd1;
            asm_d  = imem_wdata;
          end
          if (bus.in_load_last) state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_d      = S_RUN;
        core_rst_n_d = 1'b1;
        done_d       = 1'b1;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      state_q      <= S_LOAD;
      lane_q       <= 2'd0;
      wcnt_q       <= '0;
      asm_q        <= 32'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      wcnt_q       <= wcnt_d;
      asm_q        <= asm_d;
      err_q        <= err_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge in_Clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  // Stores are only honoured once the core is running and the address is in range.
  assign dmem_we = bus.in_DM_wr_en && !in_Rst && (state_q == S_RUN) &&
                   (bus.in_addr < DMEM_BYTES);

  always_ff @(posedge in_Clk) begin
    if (dmem_we) dmem[bus.in_addr[DW+2:3]] <= bus.in_wr_data;
  end

  assign bus.out_inst = ((state_q == S_RUN) && (bus.in_inst_addr < IMEM_BYTES)) ?
                        imem[bus.in_inst_addr[IW+1:2]] : NOP;
  assign bus.out_DM_data = (bus.in_addr < DMEM_BYTES) ? dmem[bus.in_addr[DW+2:3]] : 64'b0;
  assign bus.out_load_ready = (state_q == S_LOAD);
  assign bus.out_core_Rst_N = core_rst_n_q;
  assign bus.out_load_done  = done_q;
  assign bus.out_err        = err_q;
endmodule
